// File: rtl/data_memory_cache_port.sv
// Request/response front end for the cache data-memory array: one access at a time,
// registered responses, byte-masked writes performed as read-modify-write.

package cache;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 32;

    typedef logic [DATA_W-1:0] cache_data_t;

    typedef struct packed {
        logic               we;
        logic [INDEX_W-1:0] index;
    } cache_req_t;
endpackage

module data_memory_cache_port #(
    parameter  int size = 1024,
    localparam int IW   = $clog2(size),
    localparam int NB   = $bits(cache::cache_data_t) / 8
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IW-1:0]       req_index,
    input  logic                req_we,
    input  logic [NB-1:0]       req_be,
    input  cache::cache_data_t  req_wdata,

    output logic                resp_valid,
    input  logic                resp_ready,
    output cache::cache_data_t  resp_rdata,

    output cache::cache_req_t   data_req,
    output cache::cache_data_t  data_write,
    input  cache::cache_data_t  data_read
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    localparam logic [NB-1:0] BE_FULL = '1;
    localparam logic [IW:0]   SIZE_W  = (IW + 1)'(size);

    state_t             state;
    logic [IW-1:0]      hold_index;
    cache::cache_data_t merged_q;
    cache::cache_data_t merged_d;

    logic in_range;
    logic accept;
    logic full_wr;
    logic part_wr;

    assign in_range = ({1'b0, req_index} < SIZE_W);

    // NOTE: rst_n gates ready so no request (and no array write) can slip through while reset is held.
    assign req_ready = rst_n && (state == IDLE) && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign full_wr   = req_we && (req_be == BE_FULL);
    assign part_wr   = req_we && (req_be != '0) && !full_wr;

    // NOTE: every output of an always_comb block gets a default first, so no latch is inferred.
    always_comb begin
        merged_d = data_read;
        for (int b = 0; b < NB; b++) begin
            if (req_be[b]) merged_d[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    always_comb begin
        data_req   = '0;
        data_write = req_wdata;
        if (state == MERGE) begin
            data_req.index = cache::INDEX_W'(hold_index);
            data_req.we    = 1'b1;
            data_write     = merged_q;
        end else begin
            data_req.index = cache::INDEX_W'(req_index);
            data_req.we    = accept && full_wr && in_range;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_index <= '0;
            merged_q   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // NOTE: non-blocking, last assignment wins: a load below overrides this drain.
            if (resp_valid && resp_ready) resp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else if (part_wr) begin
                            state      <= MERGE;
                            hold_index <= req_index;
                            merged_q   <= merged_d;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= full_wr ? req_wdata : data_read;
                        end
                    end
                end
                MERGE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= merged_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_cache_port.sv
// Self-checking bench: directed scenarios plus randomized traffic scored against a
// transaction-level memory model and an in-order expected-response queue.

module tb_data_memory_cache_port;

    localparam int SIZE = 1024;
    localparam int IW   = $clog2(SIZE);
    localparam int NB   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [IW-1:0]      req_index;
    logic               req_we;
    logic [NB-1:0]      req_be;
    cache::cache_data_t req_wdata;
    logic               resp_valid;
    logic               resp_ready;
    cache::cache_data_t resp_rdata;
    cache::cache_req_t  data_req;
    cache::cache_data_t data_write;
    cache::cache_data_t data_read;

    data_memory_cache_port #(.size(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .data_req   (data_req),
        .data_write (data_write),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    // Data array: full-word write at the edge, combinational read.
    cache::cache_data_t mem [SIZE];
    assign data_read = mem[data_req.index[IW-1:0]];
    always @(posedge clk) if (data_req.we) mem[data_req.index[IW-1:0]] <= data_write;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: word store plus in-order expected responses.
    cache::cache_data_t ref_mem [int];
    cache::cache_data_t exp_q [$];
    cache::cache_data_t mon_word;
    bit mon_en = 1'b0;
    int exp_we = 0;
    int obs_we = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (data_req.we) obs_we++;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
                else check("resp_data", resp_rdata, exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                mon_word = ref_mem.exists(int'(req_index)) ? ref_mem[int'(req_index)] : '0;
                if (req_we && req_be != '0) begin
                    for (int b = 0; b < NB; b++)
                        if (req_be[b]) mon_word[8*b +: 8] = req_wdata[8*b +: 8];
                    ref_mem[int'(req_index)] = mon_word;
                    exp_we++;
                end
                exp_q.push_back(mon_word);
            end
        end
    end

    task automatic drive(input bit v, input bit we, input int idx, input logic [NB-1:0] be,
                         input logic [31:0] wd, input bit rr);
        @(posedge clk);
        #1;
        req_valid  = v;
        req_we     = we;
        req_index  = IW'(idx);
        req_be     = be;
        req_wdata  = wd;
        resp_ready = rr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    endtask

    task automatic write_word(input int idx, input logic [31:0] wd);
        drive(1'b1, 1'b1, idx, 4'hF, wd, 1'b1);
        idle();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_index  = IW'(3);
        req_be     = 4'hF;
        req_wdata  = 32'hCAFEF00D;
        resp_ready = 1'b1;

        // Reset state: a pending full write must not reach the array
        #7;
        check("rst_we", data_req.we, 0);
        check("rst_resp_valid", resp_valid, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1);
        mon_en = 1'b1;

        // Full-mask write then read
        drive(1'b1, 1'b1, 5, 4'hF, 32'h11223344, 1'b1);
        @(negedge clk);
        check("full_we", data_req.we, 1);
        check("full_data_write", data_write, 32'h11223344);
        drive(1'b1, 1'b0, 5, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("full_resp_valid", resp_valid, 1);
        check("full_resp", resp_rdata, 32'h11223344);
        check("read_no_we", data_req.we, 0);
        idle();
        @(negedge clk);
        check("raw_resp_valid", resp_valid, 1);
        check("raw_resp", resp_rdata, 32'h11223344);

        // Partial write
        write_word(7, 32'h11223344);
        drive(1'b1, 1'b1, 7, 4'b0010, 32'hAABBCCDD, 1'b1);
        @(negedge clk);
        check("part_accept", req_ready, 1);
        check("part_no_we_accept", data_req.we, 0);
        idle();
        @(negedge clk);
        check("merge_we", data_req.we, 1);
        check("merge_data_write", data_write, 32'h1122CC44);
        check("merge_index", data_req.index, 7);
        check("merge_no_resp", resp_valid, 0);
        check("merge_busy", req_ready, 0);
        idle();
        @(negedge clk);
        check("part_resp_valid", resp_valid, 1);
        check("part_resp", resp_rdata, 32'h1122CC44);
        check("part_we_single", data_req.we, 0);
        drive(1'b1, 1'b0, 7, 4'h0, 32'h0, 1'b1);
        idle();
        @(negedge clk);
        check("part_readback", resp_rdata, 32'h1122CC44);

        // Back-pressure
        drive(1'b1, 1'b0, 5, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("bp_first_accept", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 7, 4'h0, 32'h0, 1'b0);
            @(negedge clk);
            check("bp_ready_low", req_ready, 0);
            check("bp_resp_held", resp_rdata, 32'h11223344);
            check("bp_no_we", data_req.we, 0);
        end
        drive(1'b1, 1'b0, 7, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("bp_release_ready", req_ready, 1);
        drive(1'b1, 1'b0, 5, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("bp_b2b_valid1", resp_valid, 1);
        check("bp_b2b_data1", resp_rdata, 32'h1122CC44);
        idle();
        @(negedge clk);
        check("bp_b2b_valid2", resp_valid, 1);
        check("bp_b2b_data2", resp_rdata, 32'h11223344);

        // Zero-mask write
        write_word(9, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 9, 4'h0, 32'h12345678, 1'b1);
        @(negedge clk);
        check("zero_no_we", data_req.we, 0);
        idle();
        @(negedge clk);
        check("zero_resp", resp_rdata, 32'hDEADBEEF);
        check("zero_mem", mem[9], 32'hDEADBEEF);

        // Mid-stream reset with a held response
        idle();
        mon_en = 1'b0;
        drive(1'b1, 1'b0, 9, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("mid_held_valid", resp_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_rdata", resp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", req_ready, 1);
        mon_en = 1'b1;

        // Reset during MERGE
        write_word(11, 32'h55667788);
        idle();
        mon_en = 1'b0;
        drive(1'b1, 1'b1, 11, 4'b0001, 32'hFFFFFFFF, 1'b1);
        idle();
        @(negedge clk);
        check("mrst_in_merge", data_req.we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_we_drop", data_req.we, 0);
        @(posedge clk);
        #1;
        check("mrst_no_resp", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_mem_kept", mem[11], 32'h55667788);
        mon_en = 1'b1;
        drive(1'b1, 1'b0, 11, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("mrst_next_accept", req_ready, 1);
        idle();
        @(negedge clk);
        check("mrst_readback", resp_rdata, 32'h55667788);

        // Randomized traffic over a small index window to force collisions
        for (int i = 0; i < 16; i++) write_word(i, $urandom);
        for (int c = 0; c < 3000; c++) begin
            int mode;
            logic [NB-1:0] be;
            mode = $urandom_range(0, 3);
            be   = (mode == 0) ? 4'hF : (mode == 1) ? 4'h0 : NB'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), be, $urandom, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 5; i++) idle();
        @(negedge clk);
        mon_en = 1'b0;
        check("drain_queue_empty", exp_q.size(), 0);
        check("we_pulse_count", obs_we, exp_we);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
